// File: rtl/timer_cnt_cmp_pkg.sv
// Shared encodings and reset values for the 64-bit timer counter/compare block.
package timer_pkg;

    localparam int TIMER_CNT_W  = 64;
    localparam int TIMER_DATA_W = 32;

    typedef enum logic [2:0] {
        SEL_CNT_LO = 3'd0,
        SEL_CNT_HI = 3'd1,
        SEL_CMP_LO = 3'd2,
        SEL_CMP_HI = 3'd3,
        SEL_INT_ST = 3'd4
    } wr_sel_e;

    localparam logic [TIMER_CNT_W-1:0] CNT_RST     = {TIMER_CNT_W{1'b0}};
    localparam logic [TIMER_CNT_W-1:0] CMP_RST_DEF = {TIMER_CNT_W{1'b1}};
    localparam int                     INT_CLR_BIT = 0;

endpackage

// File: rtl/timer_cnt_cmp_int_flag.sv
// Sticky status bit: set has priority over write-1-to-clear; irq is the status gated by enable.
module timer_int_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    input  logic en,
    output logic st,
    output logic irq
);

    logic st_r;
    logic st_nxt_s;

    // Next status: set wins over clear, otherwise hold
    always_comb begin
        st_nxt_s = st_r;
        if (set) begin
            st_nxt_s = 1'b1;
        end else if (clr) begin
            st_nxt_s = 1'b0;
        end else begin
            st_nxt_s = st_r;
        end
    end

    // Status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r <= 1'b0;
        end else begin
            st_r <= st_nxt_s;
        end
    end

    assign st  = st_r;
    assign irq = st_r & en;

endmodule

// File: rtl/timer_cnt_cmp.sv
// 64-bit free-running timer count with compare value and sticky match interrupt.
// Optional build macro TIMER_AUTO_RELOAD_EN turns the counter into a periodic timer.
module timer_cnt_cmp
    import timer_pkg::*;
#(
    parameter int                 CNT_W   = TIMER_CNT_W,
    parameter int                 DATA_W  = TIMER_DATA_W,
    parameter logic [CNT_W-1:0]   CMP_RST = CMP_RST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cnt_en,
    input  logic              wr_en,
    input  logic [2:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              int_en,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [CNT_W-1:0]  cmp_val,
    output logic              int_st,
    output logic              tim_int
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cmp_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cmp_nxt_s;
    logic             wr_cnt_lo_s;
    logic             wr_cnt_hi_s;
    logic             wr_cmp_lo_s;
    logic             wr_cmp_hi_s;
    logic             wr_int_st_s;
    logic             int_clr_s;
    logic             match_s;

    // Write target decode; selects 5-7 fall through to no action
    always_comb begin
        wr_cnt_lo_s = 1'b0;
        wr_cnt_hi_s = 1'b0;
        wr_cmp_lo_s = 1'b0;
        wr_cmp_hi_s = 1'b0;
        wr_int_st_s = 1'b0;
        if (wr_en) begin
            case (wr_sel)
                SEL_CNT_LO: wr_cnt_lo_s = 1'b1;
                SEL_CNT_HI: wr_cnt_hi_s = 1'b1;
                SEL_CMP_LO: wr_cmp_lo_s = 1'b1;
                SEL_CMP_HI: wr_cmp_hi_s = 1'b1;
                SEL_INT_ST: wr_int_st_s = 1'b1;
                default:    wr_int_st_s = 1'b0;
            endcase
        end else begin
            wr_int_st_s = 1'b0;
        end
    end

    assign match_s   = (cnt_r == cmp_r);
    assign int_clr_s = wr_int_st_s & wr_data[INT_CLR_BIT];

    // Counter next state: half writes beat increment (and reload), which beats hold
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (wr_cnt_lo_s) begin
            cnt_nxt_s[DATA_W-1:0] = wr_data;
        end else if (wr_cnt_hi_s) begin
            cnt_nxt_s[CNT_W-1:DATA_W] = wr_data;
        end else if (cnt_en) begin
`ifdef TIMER_AUTO_RELOAD_EN
            if (match_s) begin
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
`else
            cnt_nxt_s = cnt_r + CNT_ONE;
`endif
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Compare next state: each half write leaves the other half untouched
    always_comb begin
        cmp_nxt_s = cmp_r;
        if (wr_cmp_lo_s) begin
            cmp_nxt_s[DATA_W-1:0] = wr_data;
        end else if (wr_cmp_hi_s) begin
            cmp_nxt_s[CNT_W-1:DATA_W] = wr_data;
        end else begin
            cmp_nxt_s = cmp_r;
        end
    end

    // Count and compare registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_W'(CNT_RST);
            cmp_r <= CMP_RST;
        end else begin
            cnt_r <= cnt_nxt_s;
            cmp_r <= cmp_nxt_s;
        end
    end

    timer_int_flag u_int_flag (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (match_s),
        .clr   (int_clr_s),
        .en    (int_en),
        .st    (int_st),
        .irq   (tim_int)
    );

    assign cnt_val = cnt_r;
    assign cmp_val = cmp_r;

endmodule
